// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU constants and the writeback-source encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_RA   = 5'd31;

   // Origin of the value committed to the register file
   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_MEM  = 2'd1,
      WB_LINK = 2'd2
   } wb_src_e;

endpackage
`default_nettype wire

// File: rtl/regfile_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : regfile_2r1w
// Description : Raw register storage with two asynchronous read ports and one
//               synchronous write port. Reads return stored contents only;
//               bypass and r0 masking live in the wrapper.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_2r1w #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b
);

   localparam int NREGS = 2 ** ADDR_W;

   logic [DATA_W-1:0] r_mem [NREGS];

   // Storage: async clear of every entry, single write port otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            r_mem[i] <= '0;
         end
      end else if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   assign rdata_a = r_mem[raddr_a];
   assign rdata_b = r_mem[raddr_b];

endmodule
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile
// Description : Writeback stage: selects the writeback value, applies the
//               link destination override, commits to the register file,
//               serves two bypassed read ports and counts committed writes.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_regwrite,
   input  logic              wb_memtoreg,
   input  logic              wb_link,
   input  logic [DATA_W-1:0] wb_memdata,
   input  logic [DATA_W-1:0] wb_aluresult,
   input  logic [DATA_W-1:0] wb_linkpc,
   input  logic [ADDR_W-1:0] wb_rd,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   output logic [ADDR_W-1:0] wb_dest,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_we,
   output logic [CNT_W-1:0]  wb_count
);

   import cpu_pkg::*;

   localparam logic [ADDR_W-1:0] C_ZERO = ADDR_W'(REG_ZERO);
   localparam logic [ADDR_W-1:0] C_RA   = ADDR_W'(REG_RA);

   wb_src_e           w_src;
   logic [DATA_W-1:0] w_raw_rs;
   logic [DATA_W-1:0] w_raw_rt;

   // Source priority: a link write overrides the memory/ALU choice
   always_comb begin
      w_src = WB_ALU;
      if (wb_link) begin
         w_src = WB_LINK;
      end else if (wb_memtoreg) begin
         w_src = WB_MEM;
      end
   end

   // Writeback value mux, also exported to the forwarding unit
   always_comb begin
      wb_data = wb_aluresult;
      case (w_src)
         WB_MEM:  wb_data = wb_memdata;
         WB_LINK: wb_data = wb_linkpc;
         default: wb_data = wb_aluresult;
      endcase
   end

   // Link writes always target the return-address register; r0 is never written
   assign wb_dest = wb_link ? C_RA : wb_rd;
   assign wb_we   = wb_regwrite && (wb_dest != C_ZERO);

   regfile_2r1w #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_storage (
      .clk     (clk),
      .rst     (rst),
      .we      (wb_we),
      .waddr   (wb_dest),
      .wdata   (wb_data),
      .raddr_a (rs_addr),
      .raddr_b (rt_addr),
      .rdata_a (w_raw_rs),
      .rdata_b (w_raw_rt)
   );

   // r0 reads as zero regardless of storage; a write in flight is bypassed
   function automatic logic [DATA_W-1:0] read_sel(
      input logic [ADDR_W-1:0] addr,
      input logic [DATA_W-1:0] raw
   );
      if (addr == C_ZERO) begin
         return '0;
      end else if (wb_we && (addr == wb_dest)) begin
         return wb_data;
      end else begin
         return raw;
      end
   endfunction

   // Read port A with r0 masking and same-cycle bypass
   always_comb begin
      rs_data = read_sel(rs_addr, w_raw_rs);
   end

   // Read port B with r0 masking and same-cycle bypass
   always_comb begin
      rt_data = read_sel(rt_addr, w_raw_rt);
   end

   // Committed-write counter; wraps silently
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_count <= '0;
      end else if (wb_we) begin
         wb_count <= wb_count + CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_regfile
// Description : Self-checking bench for wb_regfile: directed scenarios plus
//               randomized traffic against an array-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              wb_regwrite, wb_memtoreg, wb_link;
   logic [DATA_W-1:0] wb_memdata, wb_aluresult, wb_linkpc;
   logic [ADDR_W-1:0] wb_rd, rs_addr, rt_addr;
   logic [DATA_W-1:0] rs_data, rt_data, wb_data;
   logic [ADDR_W-1:0] wb_dest;
   logic              wb_we;
   logic [CNT_W-1:0]  wb_count;

   wb_regfile #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .wb_regwrite  (wb_regwrite),
      .wb_memtoreg  (wb_memtoreg),
      .wb_link      (wb_link),
      .wb_memdata   (wb_memdata),
      .wb_aluresult (wb_aluresult),
      .wb_linkpc    (wb_linkpc),
      .wb_rd        (wb_rd),
      .rs_addr      (rs_addr),
      .rt_addr      (rt_addr),
      .rs_data      (rs_data),
      .rt_data      (rt_data),
      .wb_dest      (wb_dest),
      .wb_data      (wb_data),
      .wb_we        (wb_we),
      .wb_count     (wb_count)
   );

   always #5 clk = ~clk;

   // Reference model: register contents and total committed writes
   logic [31:0] model [32];
   int unsigned n_writes;
   int          n_checks = 0;
   int          n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [4:0] m_dest();
      return wb_link ? 5'd31 : wb_rd;
   endfunction

   function automatic logic [31:0] m_data();
      if (wb_link)     return wb_linkpc;
      if (wb_memtoreg) return wb_memdata;
      return wb_aluresult;
   endfunction

   function automatic logic m_we();
      return wb_regwrite && (m_dest() != 5'd0);
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 5'd0)                 return 32'd0;
      if (m_we() && a == m_dest())   return m_data();
      return model[a];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) model[i] = '0;
      n_writes = 0;
   endtask

   task automatic drive(input logic rw, input logic m2r, input logic lnk,
                        input logic [31:0] md, input logic [31:0] alu,
                        input logic [31:0] lpc, input logic [4:0] rd);
      wb_regwrite = rw; wb_memtoreg = m2r; wb_link = lnk;
      wb_memdata = md; wb_aluresult = alu; wb_linkpc = lpc; wb_rd = rd;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
   endtask

   // Advance one clock; the model commits what the spec says the edge commits
   task automatic tick();
      logic       we_now;
      logic [4:0] d_now;
      logic [31:0] v_now;
      we_now = m_we(); d_now = m_dest(); v_now = m_data();
      @(posedge clk);
      if (!rst && we_now) begin
         model[d_now] = v_now;
         n_writes++;
      end
      @(negedge clk);
   endtask

   task automatic check_all(input string tag);
      #1;
      check({tag, ".dest"},  {27'd0, wb_dest}, {27'd0, m_dest()});
      check({tag, ".data"},  wb_data, m_data());
      check({tag, ".we"},    {31'd0, wb_we}, {31'd0, m_we()});
      check({tag, ".rs"},    rs_data, m_read(rs_addr));
      check({tag, ".rt"},    rt_data, m_read(rt_addr));
      check({tag, ".count"}, {28'd0, wb_count}, n_writes % 16);
   endtask

   initial begin
      rst = 1'b1;
      idle();
      rs_addr = 5'd0; rt_addr = 5'd0;
      model_clear();
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Reset state
      rs_addr = 5'd7; rt_addr = 5'd31;
      #1;
      check("rst.rs", rs_data, 32'd0);
      check("rst.rt", rt_data, 32'd0);
      check("rst.count", {28'd0, wb_count}, 32'd0);

      // ALU writeback with same-cycle bypass
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'hDEADBEEF, 32'h0, 5'd7);
      rs_addr = 5'd1; rt_addr = 5'd7;
      #1;
      check("alu.bypass_rt", rt_data, 32'hDEADBEEF);
      tick();
      idle(); rs_addr = 5'd7;
      #1;
      check("alu.rs", rs_data, 32'hDEADBEEF);
      check("alu.count", {28'd0, wb_count}, 32'd1);

      // Link beats memtoreg; r3 untouched
      drive(1'b1, 1'b1, 1'b1, 32'hA5A5A5A5, 32'h0, 32'h00400010, 5'd3);
      #1;
      check("link.dest", {27'd0, wb_dest}, 32'd31);
      check("link.data", wb_data, 32'h00400010);
      tick();
      idle(); rs_addr = 5'd31; rt_addr = 5'd3;
      #1;
      check("link.r31", rs_data, 32'h00400010);
      check("link.r3", rt_data, 32'd0);

      // Link without regwrite writes nothing
      drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h12345678, 5'd4);
      check_all("link_norw");
      tick();
      idle(); rs_addr = 5'd31;
      check_all("link_norw.after");

      // r0 protection
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFFFFFF, 32'h0, 5'd0);
      rs_addr = 5'd0; rt_addr = 5'd0;
      #1;
      check("r0.during", rs_data, 32'd0);
      check("r0.we", {31'd0, wb_we}, 32'd0);
      tick();
      idle();
      #1;
      check("r0.after", rs_data, 32'd0);
      check("r0.count", {28'd0, wb_count}, 32'd2);

      // Back-to-back writes and dual read of the bypassed register
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'd1, 32'h0, 5'd9);
      tick();
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'd2, 32'h0, 5'd9);
      rs_addr = 5'd9; rt_addr = 5'd9;
      #1;
      check("b2b.rs", rs_data, 32'd2);
      check("b2b.rt", rt_data, 32'd2);
      tick();
      idle();
      #1;
      check("b2b.after", rs_data, 32'd2);
      check("b2b.count", {28'd0, wb_count}, 32'd4);

      // Asynchronous reset mid-run
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h1234, 32'h0, 5'd5);
      tick();
      idle(); rs_addr = 5'd5;
      #1;
      check("rst2.pre", rs_data, 32'h1234);
      #2 rst = 1'b1;
      #1;
      check("rst2.rs", rs_data, 32'd0);
      check("rst2.count", {28'd0, wb_count}, 32'd0);
      model_clear();
      // A write request held across an edge under reset must not land
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'hCAFEF00D, 32'h0, 5'd5);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      idle();
      #1;
      check("rst2.held_r5", rs_data, 32'd0);
      check("rst2.held_count", {28'd0, wb_count}, 32'd0);

      // Counter wrap at 4 bits: 17 effective writes from zero
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, 1'b0, 1'b0, 32'h0, 32'(i), 32'h0, 5'(1 + (i % 30)));
         tick();
      end
      idle();
      #1;
      check("wrap.count", {28'd0, wb_count}, 32'd1);

      // Randomized traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1), ($urandom_range(0, 7) == 0),
               $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)));
         rs_addr = ($urandom_range(0, 2) == 0) ? wb_rd : 5'($urandom_range(0, 31));
         rt_addr = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
         check_all("rand");
         tick();
      end

      // Final sweep of all registers through both ports
      idle();
      for (int a = 0; a < 32; a++) begin
         rs_addr = 5'(a); rt_addr = 5'(31 - a);
         #1;
         check("sweep.rs", rs_data, m_read(rs_addr));
         check("sweep.rt", rt_data, m_read(rt_addr));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-side consumer of the MEM/WB pipeline register outputs.
- Selects the writeback value (memory data, ALU result, or link PC) and commits it to a 32x32 general-purpose register file.
- Serves the ID stage through two combinational read ports, with same-cycle write-to-read bypass.
- Exposes the selected writeback value for EX forwarding, plus a committed-write counter for debug.

Parameters:
- DATA_W, 32, register and datapath width
- ADDR_W, 5, register address width (2**ADDR_W registers)
- CNT_W, 32, width of committed-write counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- wb_regwrite  in  1  RegWrite from MEM/WB
- wb_memtoreg  in  1  MemtoReg from MEM/WB; 1 selects wb_memdata
- wb_link  in  1  jump-and-link writeback; forces destination to r31 and data to wb_linkpc
- wb_memdata  in  DATA_W  load data from MEM/WB
- wb_aluresult  in  DATA_W  ALU result from MEM/WB
- wb_linkpc  in  DATA_W  return address for link writes
- wb_rd  in  ADDR_W  destination register from MEM/WB
- rs_addr  in  ADDR_W  read port A address
- rt_addr  in  ADDR_W  read port B address
- rs_data  out  DATA_W  read port A data (combinational)
- rt_data  out  DATA_W  read port B data (combinational)
- wb_dest  out  ADDR_W  effective destination (combinational), for the forwarding unit
- wb_data  out  DATA_W  selected writeback value (combinational), for the forwarding unit
- wb_we  out  1  effective write enable (combinational)
- wb_count  out  CNT_W  number of committed register writes

Behaviour:
- Reset (rst=1, asynchronous): all 32 registers clear to 0; wb_count clears to 0. Combinational outputs follow the cleared state. While rst is high, no write occurs regardless of inputs. Deassertion takes effect at the next rising clk edge.
- Destination: wb_dest = wb_link ? 31 : wb_rd.
- Data select, priority wb_link > wb_memtoreg: wb_data = wb_link ? wb_linkpc : (wb_memtoreg ? wb_memdata : wb_aluresult).
- wb_we = wb_regwrite && (wb_dest != 0).
  - wb_link without wb_regwrite writes nothing.
  - A write to r0 is discarded.
- Write: on a rising clk edge with wb_we=1, reg[wb_dest] <= wb_data. Latency is 1 cycle to storage; 0 cycles to readers via the bypass.
- Read (each port independent, purely combinational):
  - addr == 0 -> 0.
  - else if wb_we && addr == wb_dest -> wb_data (bypass).
  - else -> reg[addr].
- Both ports may read the same address, including the bypassed one; both return identical data.
- r0 always reads 0 and is never written, even if storage is corrupted.
- wb_count increments by 1 on each rising edge where wb_we=1. Writes to r0 and cycles with wb_regwrite=0 do not count. Wraps from 2**CNT_W-1 to 0 silently.
- X/unknown inputs while wb_regwrite=0 have no effect on state.
- Back-to-back writes to the same register: the last write wins. A read in the cycle of the second write sees the second value via bypass.

Decomposition:
- Shared package `cpu_pkg`: constants REG_ZERO=5'd0, REG_RA=5'd31, DATA_W, ADDR_W; enum for writeback source (WB_ALU, WB_MEM, WB_LINK).
- Sub-module `regfile_2r1w`: storage array, async reset, write port, raw read ports. No bypass and no r0 masking inside it.
- Top level `wb_regfile` contains: source mux, destination override, r0 masking, bypass, and counter.

Test Plan:
- Reset: assert rst mid-simulation after writing r5=0x1234 -> rs_addr=5 reads 0 immediately (before the next clk); wb_count=0.
- ALU writeback: wb_regwrite=1, memtoreg=0, rd=7, alu=0xDEADBEEF, then 1 clk -> rs_addr=7 reads 0xDEADBEEF; wb_count=1. In the same cycle, before the edge, rt_addr=7 already reads 0xDEADBEEF via bypass.
- Memory vs link priority: memtoreg=1, memdata=0xA5A5A5A5, link=1, linkpc=0x00400010, rd=3 -> r31=0x00400010; r3 unchanged (0); wb_dest=31.
- r0 protection: regwrite=1, rd=0, alu=0xFFFFFFFF -> rs_addr=0 reads 0 both during and after the edge; wb_we=0; wb_count unchanged.
- Back-to-back and dual read: write r9=1, then r9=2 on consecutive cycles -> during the second cycle rs_addr=rt_addr=9 both read 2; after it, r9=2; wb_count +2.
- Counter wrap: with CNT_W=4, perform 17 effective writes -> wb_count=1.
